// File: rtl/board_loader_if.sv
// Load-side bus between the new-game control logic and the board loader.
// The loader is the slave: it takes the request and drives the cell load strobes.
interface board_loader_if;
    logic        new_game;
    logic        busy;
    logic        done;
    logic [15:0] load_en;
    logic [1:0]  load_val;
    logic [3:0]  cell_idx;
    logic [1:0]  layout_id;
    logic [2:0]  ship_count;

    modport master (
        output new_game,
        input  busy, done, load_en, load_val, cell_idx, layout_id, ship_count
    );

    modport slave (
        input  new_game,
        output busy, done, load_en, load_val, cell_idx, layout_id, ship_count
    );
endinterface

// File: rtl/board_loader.sv
// Walks the 4x4 board one cell per cycle on new_game, writing ship/water codes from a layout mask.
// Define BOARD_LOADER_RANDOM_EN to pick layouts from a 4-bit LFSR instead of a round-robin counter.
module board_loader #(
    parameter logic [15:0] LAYOUT0    = 16'h0033,
    parameter logic [15:0] LAYOUT1    = 16'h8421,
    parameter logic [15:0] LAYOUT2    = 16'hF001,
    parameter logic [15:0] LAYOUT3    = 16'h0660,
    parameter logic [1:0]  SHIP_CODE  = 2'b01,
    parameter logic [1:0]  WATER_CODE = 2'b00
) (
    input  logic           clk,
    input  logic           reset,
    board_loader_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [15:0] mask, mask_nxt;
    logic [1:0]  sel;
    logic        accept;

    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [15:0] load_en_q, load_en_d;
    logic [1:0]  load_val_q, load_val_d;
    logic [3:0]  cell_idx_q, cell_idx_d;
    logic [1:0]  layout_id_q, layout_id_d;
    logic [2:0]  ship_count_q, ship_count_d;

    function automatic logic [15:0] layout_mask(input logic [1:0] id);
        logic [15:0] m;
        case (id)
            2'd0:    m = LAYOUT0;
            2'd1:    m = LAYOUT1;
            2'd2:    m = LAYOUT2;
            default: m = LAYOUT3;
        endcase
        return m;
    endfunction

    // Custom layouts may hold more than 7 ships; clamp rather than wrap the 3-bit count.
    function automatic logic [2:0] sat_popcount(input logic [15:0] m);
        logic [4:0] n;
        n = 5'd0;
        for (int i = 0; i < 16; i++) begin
            n = n + {4'd0, m[i]};
        end
        return (n > 5'd7) ? 3'd7 : n[2:0];
    endfunction

`ifdef BOARD_LOADER_RANDOM_EN
    logic [3:0] lfsr;

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= 4'b0001;
        end else begin
            lfsr <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
        end
    end

    assign sel = lfsr[1:0];
`else
    logic [1:0] game_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            game_cnt <= 2'd0;
        end else if (state == S_DONE) begin
            game_cnt <= game_cnt + 2'd1;
        end
    end

    assign sel = game_cnt;
`endif

    assign accept = (state == S_IDLE) && bus.new_game;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Mask is only meaningful once a load has been accepted, so it carries no reset.
    always_ff @(posedge clk) begin
        mask <= mask_nxt;
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mask_nxt  = mask;
        unique case (state)
            S_IDLE: begin
                if (bus.new_game) begin
                    state_nxt = S_LOAD;
                    cnt_nxt   = 4'd0;
                    mask_nxt  = layout_mask(sel);
                end
            end
            S_LOAD: begin
                cnt_nxt = cnt + 4'd1;
                if (cnt == 4'd15) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the upcoming state and registered, so cell k is strobed
    // in the cycle right after the edge that moves the counter to k.
    always_comb begin
        busy_d       = 1'b0;
        done_d       = 1'b0;
        load_en_d    = 16'd0;
        load_val_d   = 2'b00;
        cell_idx_d   = 4'd0;
        layout_id_d  = layout_id_q;
        ship_count_d = ship_count_q;
        unique case (state_nxt)
            S_LOAD: begin
                busy_d     = 1'b1;
                load_en_d  = 16'd1 << cnt_nxt;
                cell_idx_d = cnt_nxt;
                load_val_d = mask_nxt[cnt_nxt] ? SHIP_CODE : WATER_CODE;
            end
            S_DONE: begin
                done_d       = 1'b1;
                ship_count_d = sat_popcount(mask);
            end
            default: begin
            end
        endcase
        if (accept) begin
            layout_id_d = sel;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            load_en_q    <= 16'd0;
            load_val_q   <= 2'b00;
            cell_idx_q   <= 4'd0;
            layout_id_q  <= 2'd0;
            ship_count_q <= 3'd0;
        end else begin
            busy_q       <= busy_d;
            done_q       <= done_d;
            load_en_q    <= load_en_d;
            load_val_q   <= load_val_d;
            cell_idx_q   <= cell_idx_d;
            layout_id_q  <= layout_id_d;
            ship_count_q <= ship_count_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.load_en    = load_en_q;
    assign bus.load_val   = load_val_q;
    assign bus.cell_idx   = cell_idx_q;
    assign bus.layout_id  = layout_id_q;
    assign bus.ship_count = ship_count_q;

endmodule
